// File: rtl/touch_pkg.sv
// touch_pkg
// Shared definitions for the resistive touch panel sampler: sampler FSM
// states, default conversion commands for the panel controller, coordinate
// width and the interval-load helper used by the sampler.
package touch_pkg;

  localparam int COORD_W = 12;

  // 12-bit differential conversions, X and Y channels.
  localparam logic [7:0] CMD_X_DEF = 8'hD0;
  localparam logic [7:0] CMD_Y_DEF = 8'h90;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SETUP,
    S_XFER_X,
    S_XFER_Y,
    S_HOLD
  } state_t;

  // A zero interval would never expire, so it is treated as one tick.
  function automatic logic [15:0] interval_load(input logic [15:0] period);
    return (period == 16'd0) ? 16'd1 : period;
  endfunction

endpackage

// File: rtl/touch_spi_xfer.sv
// touch_spi_xfer
// One 24-clock command/read on the panel controller's serial bus: 8 command
// bits MSB first, then 16 read clocks. Read clocks 1..12 carry the result
// MSB first; read clock 0 and 13..15 are discarded.
// Ports:
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   start                  : one-cycle pulse, begins a transfer with cmd
//   cmd                    : 8-bit command shifted out on tp_din
//   tp_dout                : controller serial data out
//   tp_dclk, tp_din        : serial clock and data to the controller
//   done                   : one-cycle pulse when the transfer has finished
//   result                 : 12-bit conversion result, held until next start
module touch_spi_xfer
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               start,
  input  logic [7:0]         cmd,
  input  logic               tp_dout,
  output logic               tp_dclk,
  output logic               tp_din,
  output logic               done,
  output logic [COORD_W-1:0] result
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       LAST_CLK = 5'd23;
  // Clock indices (within the 24) whose rising edge carries a result bit.
  localparam logic [4:0]       RD_FIRST = 5'd9;
  localparam logic [4:0]       RD_LAST  = 5'd20;

  logic             busy;
  logic [DIV_W-1:0] div_cnt;
  logic [4:0]       bit_cnt;
  logic [7:0]       cmd_sr;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees pre-edge values regardless of statement order.
  always_ff @(posedge clk_clk) begin
    // NOTE: reset is synchronous; it is just the highest-priority branch.
    if (!reset_reset_n) begin
      busy    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      cmd_sr  <= '0;
      tp_dclk <= 1'b0;
      tp_din  <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy    <= 1'b1;
        div_cnt <= '0;
        bit_cnt <= '0;
        tp_dclk <= 1'b0;
        tp_din  <= cmd[7];
        cmd_sr  <= {cmd[6:0], 1'b0};
        result  <= '0;
      end else if (busy) begin
        if (div_cnt != DIV_LAST) begin
          div_cnt <= div_cnt + 1'b1;
        end else begin
          div_cnt <= '0;
          if (!tp_dclk) begin
            // Rising edge: sample the controller, which updates on falling.
            tp_dclk <= 1'b1;
            if (bit_cnt >= RD_FIRST && bit_cnt <= RD_LAST)
              result <= {result[COORD_W-2:0], tp_dout};
          end else begin
            // Falling edge: the only place tp_din may change. Zeros shifted
            // into cmd_sr keep tp_din low through the read clocks.
            tp_dclk <= 1'b0;
            if (bit_cnt == LAST_CLK) begin
              busy   <= 1'b0;
              done   <= 1'b1;
              tp_din <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tp_din  <= cmd_sr[7];
              cmd_sr  <= {cmd_sr[6:0], 1'b0};
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/touch_sampler.sv
// touch_sampler
// Periodically samples X and Y from a resistive touch controller while the
// pen is down and sampling is enabled. Each transaction is one chip-select
// window holding an X transfer followed by a Y transfer.
// Ports:
//   clk_clk, reset_reset_n : clock, synchronous active-low reset
//   en                     : sampling enable
//   smp_period             : sample interval in PRESCALE ticks (0 acts as 1)
//   tp_pen_irq_n           : asynchronous active-low pen interrupt
//   tp_dout                : controller serial data out
//   tp_cs_n, tp_dclk, tp_din : controller chip select, clock, data in
//   pen_down               : synchronized pen state
//   xy_valid               : one-cycle strobe on new coordinates
//   x_pos, y_pos           : last valid coordinates
module touch_sampler
  import touch_pkg::*;
#(
  parameter int         CLK_DIV  = 25,
  parameter int         PRESCALE = 50,
  parameter logic [7:0] CMD_X    = CMD_X_DEF,
  parameter logic [7:0] CMD_Y    = CMD_Y_DEF
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               en,
  input  logic [15:0]        smp_period,
  input  logic               tp_pen_irq_n,
  input  logic               tp_dout,
  output logic               tp_cs_n,
  output logic               tp_dclk,
  output logic               tp_din,
  output logic               pen_down,
  output logic               xy_valid,
  output logic [COORD_W-1:0] x_pos,
  output logic [COORD_W-1:0] y_pos
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam int               PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

  state_t               state;
  logic                 pen_s1, pen_s2;
  logic [15:0]          int_cnt;
  logic [PRE_W-1:0]     pre_cnt;
  logic [DIV_W-1:0]     ph_cnt;
  logic [COORD_W-1:0]   x_res;
  logic                 xfer_start;
  logic                 xfer_done;
  logic [COORD_W-1:0]   xfer_result;
  logic [7:0]           xfer_cmd;

  // Two-flop synchronizer; idles at 1 (pen up).
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pen_s1 <= 1'b1;
      pen_s2 <= 1'b1;
    end else begin
      pen_s1 <= tp_pen_irq_n;
      pen_s2 <= pen_s1;
    end
  end

  assign pen_down = ~pen_s2;

  // The start pulse is issued on the cycle the FSM is already in the
  // matching XFER state, so the command follows the current state.
  assign xfer_cmd = (state == S_XFER_Y) ? CMD_Y : CMD_X;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      tp_cs_n    <= 1'b1;
      xy_valid   <= 1'b0;
      x_pos      <= '0;
      y_pos      <= '0;
      int_cnt    <= '0;
      pre_cnt    <= '0;
      ph_cnt     <= '0;
      x_res      <= '0;
      xfer_start <= 1'b0;
    end else begin
      xy_valid   <= 1'b0;
      xfer_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && pen_down) begin
            state   <= S_WAIT;
            int_cnt <= interval_load(smp_period);
            pre_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (!en || !pen_down) begin
            state   <= S_IDLE;
            int_cnt <= '0;
            pre_cnt <= '0;
          end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            if (int_cnt <= 16'd1) begin
              int_cnt <= '0;
              state   <= S_SETUP;
              tp_cs_n <= 1'b0;
              ph_cnt  <= '0;
            end else begin
              int_cnt <= int_cnt - 1'b1;
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end
        S_SETUP: begin
          if (ph_cnt == DIV_LAST) begin
            ph_cnt     <= '0;
            state      <= S_XFER_X;
            xfer_start <= 1'b1;
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        S_XFER_X: begin
          // Chip select stays low straight into the Y transfer.
          if (xfer_done) begin
            x_res      <= xfer_result;
            state      <= S_XFER_Y;
            xfer_start <= 1'b1;
          end
        end
        S_XFER_Y: begin
          if (xfer_done) begin
            state  <= S_HOLD;
            ph_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (ph_cnt == DIV_LAST) begin
            ph_cnt  <= '0;
            tp_cs_n <= 1'b1;
            // The transfer always completes; a released pen only drops data.
            // y comes straight from the sub-module, which holds it until the
            // next start.
            if (pen_down) begin
              xy_valid <= 1'b1;
              x_pos    <= x_res;
              y_pos    <= xfer_result;
            end
            if (en && pen_down) begin
              state   <= S_WAIT;
              int_cnt <= interval_load(smp_period);
              pre_cnt <= '0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            ph_cnt <= ph_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  touch_spi_xfer #(
    .CLK_DIV(CLK_DIV)
  ) u_xfer (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .start         (xfer_start),
    .cmd           (xfer_cmd),
    .tp_dout       (tp_dout),
    .tp_dclk       (tp_dclk),
    .tp_din        (tp_din),
    .done          (xfer_done),
    .result        (xfer_result)
  );

endmodule

// File: doc/touch_sampler.md
TOUCH_SAMPLER -- requirements
Module: touch_sampler

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide CLK_DIV, 25, clk_clk cycles per half-period of tp_dclk (minimum 2).
REQ-002 SHALL provide PRESCALE, 50, clk_clk cycles per smp_period tick (1 us at 50 MHz).
REQ-003 SHALL provide CMD_X, 8'hD0, 12-bit differential X conversion command.
REQ-004 SHALL provide CMD_Y, 8'h90, 12-bit differential Y conversion command.
Ports (name, direction, width, meaning):
REQ-005 SHALL provide clk_clk, in, 1, sole clock; all logic on its rising edge.
REQ-006 SHALL provide reset_reset_n, in, 1, synchronous active-low reset.
REQ-007 SHALL provide en, in, 1, sampling enable (driven by the touch_ctrl PIO).
REQ-008 SHALL provide smp_period, in, 16, sample interval in PRESCALE ticks (from the pen_smp_period PIO).
REQ-009 SHALL provide tp_pen_irq_n, in, 1, panel pen interrupt, active low, asynchronous.
REQ-010 SHALL provide tp_dout, in, 1, controller serial data out.
REQ-011 SHALL provide tp_cs_n, tp_dclk, tp_din, out, 1 each, controller chip select, serial clock and serial data in.
REQ-012 SHALL provide pen_down, out, 1, synchronized pen state (also feeds touch_pen_intr).
REQ-013 SHALL provide xy_valid, out, 1, one-cycle strobe marking new coordinates.
REQ-014 SHALL provide x_pos and y_pos, out, 12 each, last valid coordinates.

Function
REQ-015 SHALL synchronize tp_pen_irq_n through two flops; pen_down = NOT synchronized value (2-cycle latency).
REQ-016 SHALL implement states IDLE, WAIT, SETUP, XFER_X, XFER_Y, HOLD.
REQ-017 IDLE -> WAIT SHALL occur when en=1 and pen_down=1; the interval counter loads max(smp_period,1) and the prescaler clears.
REQ-018 WAIT SHALL decrement the interval counter once per PRESCALE cycles; at zero -> SETUP. en=0 or pen_down=0 in WAIT SHALL return to IDLE.
REQ-019 SETUP SHALL drive tp_cs_n low for CLK_DIV cycles with tp_dclk low, then -> XFER_X.
REQ-020 Each XFER state SHALL run 24 tp_dclk periods: 8 command bits (MSB first) followed by 16 read clocks.
REQ-021 tp_din SHALL change only while tp_dclk is low, and SHALL be 0 during the read clocks.
REQ-022 tp_dout SHALL be sampled on the clk_clk cycle tp_dclk rises; read clocks 1..12 (0-indexed) form the result MSB first, and clocks 0 and 13..15 are discarded.
REQ-023 XFER_X SHALL go -> XFER_Y with tp_cs_n held low between them; XFER_Y SHALL go -> HOLD.
REQ-024 HOLD SHALL last CLK_DIV cycles with tp_dclk low, then raise tp_cs_n.
REQ-025 On the cycle tp_cs_n rises, if pen_down=1 then x_pos/y_pos SHALL update and xy_valid SHALL pulse for exactly 1 cycle; if pen_down=0 the results SHALL be discarded with no strobe.
REQ-026 After HOLD the FSM SHALL go -> WAIT (reload) if en=1 and pen_down=1, else -> IDLE.
REQ-027 Pen release or en=0 during SETUP/XFER/HOLD SHALL NOT abort the transaction; it completes, and the data is then dropped per REQ-025.
REQ-028 A change to smp_period SHALL take effect only at the next counter load.
REQ-029 x_pos/y_pos SHALL hold their values between strobes.

Reset
REQ-030 While reset_reset_n=0 at a clock edge, outputs SHALL be: tp_cs_n=1, tp_dclk=0, tp_din=0, xy_valid=0, x_pos=0, y_pos=0, pen_down=0; FSM SHALL be IDLE; all counters SHALL be 0; sync flops SHALL be 1.
REQ-031 Reset asserted mid-transaction SHALL take effect at the next edge: cs_n high and no strobe.

Structure
REQ-032 Package touch_pkg SHALL hold the state enum, CMD_X/CMD_Y defaults and the coordinate width (12).
REQ-033 The design SHALL have one sub-module, touch_spi_xfer, which performs a single 24-clock command/read and returns the 12-bit result with a done pulse; touch_sampler sequences two of these transfers.

Verification
REQ-034 Bench SHALL use CLK_DIV=2, PRESCALE=1, smp_period=10, en=1, pen held down, with the model returning X=12'hABC and Y=12'h123 -> x_pos=ABC, y_pos=123, one xy_valid pulse per transaction, and 10 WAIT cycles between tp_cs_n rise and the next SETUP.
REQ-035 Bench SHALL check that tp_din shifts 1101_0000 then 1001_0000 on the tp_dclk rising edges and that tp_cs_n stays low for exactly 48 tp_dclk periods.
REQ-036 Bench SHALL release the pen at read clock 5 of XFER_Y -> transaction completes, no xy_valid, x_pos/y_pos unchanged, FSM goes to IDLE.
REQ-037 Bench SHALL set smp_period=0 -> the interval is treated as 1 tick; then write 5 during WAIT -> the current wait is unaffected and the next wait is 5 ticks.
REQ-038 Bench SHALL assert reset_reset_n=0 during XFER_X -> the next edge gives tp_cs_n=1, tp_dclk=0 and all outputs at their REQ-030 values.
REQ-039 Bench SHALL drop en in WAIT -> IDLE with no transaction; en=1 with the pen up -> remains in IDLE.
